// File: rtl/cpu_mem_loader_if.sv
// rtl/cpu_mem_loader_if.sv - command/response streams and external memory ports of cpu_mem_loader
//
// Groups the signals between the loader, its host and the CPU memories.
//   master : loader side (consumes commands, produces responses, drives both memory ports)
//   slave  : environment side (host stream source/sink, memories returning read data)
//
// Ports carried:
//   cmd_valid/cmd_ready/cmd_data   32-bit command stream, host -> loader
//   rsp_valid/rsp_ready/rsp_data   32-bit read-back stream, loader -> host
//   addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext             instruction-memory port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2   data-memory port

interface cpu_mem_loader_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_data;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;

   logic [31:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [31:0] rdata_ext;

   logic [31:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [31:0] wdata_ext_2;
   logic [31:0] rdata_ext_2;

   modport master (
      input  cmd_valid, cmd_data, rsp_ready, rdata_ext, rdata_ext_2,
      output cmd_ready, rsp_valid, rsp_data,
      output addr_ext, wen_ext, ren_ext, wdata_ext,
      output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
   );

   modport slave (
      output cmd_valid, cmd_data, rsp_ready, rdata_ext, rdata_ext_2,
      input  cmd_ready, rsp_valid, rsp_data,
      input  addr_ext, wen_ext, ren_ext, wdata_ext,
      input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
   );
endinterface

// File: rtl/cpu_mem_loader.sv
// rtl/cpu_mem_loader.sv - host-side loader driving the CPU external memory ports and run gate
//
// Consumes header/data words from the command stream, writes words into instruction or
// data memory, reads memory back onto the response stream, and enables the CPU for a
// bounded number of cycles. Every output comes straight from a register.
//
// Header word: [31:29] op, [28:16] count N, [15:0] start byte address A.
//   op 000 write imem, 001 write dmem, 010 read imem, 011 read dmem, 100 run N cycles,
//   101..111 reserved (header dropped, err set).
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         cpu_mem_loader_if.master: command/response streams and both memory ports
//   cpu_enable  CPU enable, high only while running
//   busy        high whenever not idle
//   err         sticky reserved-opcode flag, cleared by rst

module cpu_mem_loader #(
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 13
) (
   input  logic             clk,
   input  logic             rst,
   cpu_mem_loader_if.master bus,
   output logic             cpu_enable,
   output logic             busy,
   output logic             err
);

   typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RD_OUT, RUN} state_t;

   localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

   state_t             state_q, state_d;
   logic               sel_q, sel_d;            // 0: imem port, 1: dmem port
   logic [CNT_W-1:0]   cnt_q, cnt_d;            // words or cycles still to go
   logic [15:0]        addr_q, addr_d;          // byte address of the current word
   logic [2:0]         lat_q, lat_d;

   logic               cmd_ready_q, cmd_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic               cpu_en_q, cpu_en_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   logic [15:0]        a1_q, a1_d, a2_q, a2_d;
   logic [31:0]        wd1_q, wd1_d, wd2_q, wd2_d;
   logic               wen1_q, wen1_d, ren1_q, ren1_d;
   logic               wen2_q, wen2_d, ren2_q, ren2_d;

   logic [2:0]         hdr_op;
   logic [CNT_W-1:0]   hdr_cnt;
   logic [15:0]        hdr_addr;
   logic [15:0]        addr_next;
   logic               cmd_acc, rsp_acc;
   logic               wr_issue, rd_issue;
   logic [15:0]        rd_addr;

   assign hdr_op    = bus.cmd_data[31:29];
   assign hdr_cnt   = bus.cmd_data[16 +: CNT_W];
   assign hdr_addr  = bus.cmd_data[15:0];
   assign addr_next = addr_q + 16'd4;           // 16-bit wrap 0xFFFC -> 0x0000
   assign cmd_acc   = bus.cmd_valid & cmd_ready_q;
   assign rsp_acc   = rsp_valid_q & bus.rsp_ready;

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      lat_d       = lat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      err_d       = err_q;
      a1_d        = a1_q;
      a2_d        = a2_q;
      wd1_d       = wd1_q;
      wd2_d       = wd2_q;
      wen1_d      = 1'b0;
      ren1_d      = 1'b0;
      wen2_d      = 1'b0;
      ren2_d      = 1'b0;
      cpu_en_d    = 1'b0;
      wr_issue    = 1'b0;
      rd_issue    = 1'b0;
      rd_addr     = 16'h0000;

      case (state_q)
         IDLE: begin
            if (cmd_acc) begin
               if (hdr_op[2] && (hdr_op[1:0] != 2'b00)) begin
                  err_d = 1'b1;
               end else if (hdr_cnt != '0) begin
                  sel_d  = hdr_op[0];
                  cnt_d  = hdr_cnt;
                  addr_d = hdr_addr;
                  if (hdr_op[2]) begin
                     state_d  = RUN;
                     cpu_en_d = 1'b1;
                  end else if (hdr_op[1]) begin
                     state_d  = RD_REQ;
                     rd_issue = 1'b1;
                     rd_addr  = hdr_addr;
                  end else begin
                     state_d = WRITE;
                  end
               end
            end
         end

         WRITE: begin
            if (cmd_acc) begin
               wr_issue = 1'b1;
               addr_d   = addr_next;
               cnt_d    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = IDLE;
            end
         end

         RD_REQ: begin
            state_d = RD_WAIT;
            lat_d   = 3'd0;
         end

         RD_WAIT: begin
            // Read data is valid in the last wait cycle; capture it then.
            if (lat_q == LAT_LAST) begin
               rsp_data_d  = sel_q ? bus.rdata_ext_2 : bus.rdata_ext;
               rsp_valid_d = 1'b1;
               state_d     = RD_OUT;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end

         RD_OUT: begin
            if (rsp_acc) begin
               rsp_valid_d = 1'b0;
               addr_d      = addr_next;
               cnt_d       = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
               end else begin
                  state_d  = RD_REQ;
                  rd_issue = 1'b1;
                  rd_addr  = addr_next;
               end
            end
         end

         RUN: begin
            // cnt_q counts the enabled cycles left including the current one.
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
            end else begin
               cpu_en_d = 1'b1;
               cnt_d    = cnt_q - CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      // Only the selected port moves; the other keeps its address and data.
      if (wr_issue) begin
         if (sel_q) begin
            wen2_d = 1'b1;
            a2_d   = addr_q;
            wd2_d  = bus.cmd_data;
         end else begin
            wen1_d = 1'b1;
            a1_d   = addr_q;
            wd1_d  = bus.cmd_data;
         end
      end
      if (rd_issue) begin
         if (sel_d) begin
            ren2_d = 1'b1;
            a2_d   = rd_addr;
         end else begin
            ren1_d = 1'b1;
            a1_d   = rd_addr;
         end
      end

      cmd_ready_d = (state_d == IDLE) || (state_d == WRITE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= 16'h0000;
         lat_q       <= 3'd0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0;
         cpu_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         a1_q        <= 16'h0000;
         a2_q        <= 16'h0000;
         wd1_q       <= 32'h0;
         wd2_q       <= 32'h0;
         wen1_q      <= 1'b0;
         ren1_q      <= 1'b0;
         wen2_q      <= 1'b0;
         ren2_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         lat_q       <= lat_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         cpu_en_q    <= cpu_en_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         a1_q        <= a1_d;
         a2_q        <= a2_d;
         wd1_q       <= wd1_d;
         wd2_q       <= wd2_d;
         wen1_q      <= wen1_d;
         ren1_q      <= ren1_d;
         wen2_q      <= wen2_d;
         ren2_q      <= ren2_d;
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.addr_ext    = {16'h0000, a1_q};
   assign bus.wen_ext     = wen1_q;
   assign bus.ren_ext     = ren1_q;
   assign bus.wdata_ext   = wd1_q;
   assign bus.addr_ext_2  = {16'h0000, a2_q};
   assign bus.wen_ext_2   = wen2_q;
   assign bus.ren_ext_2   = ren2_q;
   assign bus.wdata_ext_2 = wd2_q;
   assign cpu_enable      = cpu_en_q;
   assign busy            = busy_q;
   assign err             = err_q;

endmodule
